// File: rtl/tomasula_types.sv
// tomasula_types: shared ALU word layout, opcodes, funct3 codes and ROB sizing
package tomasula_types;
  localparam int XLEN = 32;
  localparam int NUM_ROB = 8;
  localparam int TAG_W = $clog2(NUM_ROB);
  typedef enum logic [2:0] {
    ARITH = 3'd0,
    ARITH_IMM = 3'd1,
    LUI = 3'd2,
    AUIPC = 3'd3,
    BRANCH = 3'd4
  } op_t;
  typedef struct packed {
    op_t op;
    logic [2:0] funct3;
    logic funct7;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [TAG_W-1:0] tag;
  } alu_word_t;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR = 3'b101;
  localparam logic [2:0] F3_OR = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
endpackage

// File: rtl/alu.sv
// alu: single combinational RV32I integer lane
module alu import tomasula_types::*; (
  input  op_t             op,
  input  logic [2:0]      funct3,
  input  logic            funct7,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic [XLEN-1:0] result
);
  logic [XLEN-1:0] arith_res;
  logic [4:0] sh;
  logic lt, ltu, sub, br;
  // funct7 only selects subtract for reg-reg ops; shifts always honour it
  always_comb begin
    sh = src2[4:0];
    lt = $signed(src1) < $signed(src2);
    ltu = src1 < src2;
    sub = (op == ARITH) && funct7;
    case (funct3)
      F3_ADD:  arith_res = sub ? src1 - src2 : src1 + src2;
      F3_SLL:  arith_res = src1 << sh;
      F3_SLT:  arith_res = {{(XLEN-1){1'b0}}, lt};
      F3_SLTU: arith_res = {{(XLEN-1){1'b0}}, ltu};
      F3_XOR:  arith_res = src1 ^ src2;
      F3_SR:   arith_res = funct7 ? $unsigned($signed(src1) >>> sh) : src1 >> sh;
      F3_OR:   arith_res = src1 | src2;
      default: arith_res = src1 & src2;
    endcase
    case (funct3)
      F3_BEQ:  br = src1 == src2;
      F3_BNE:  br = src1 != src2;
      F3_BLT:  br = lt;
      F3_BGE:  br = !lt;
      F3_BLTU: br = ltu;
      F3_BGEU: br = !ltu;
      default: br = 1'b0;
    endcase
    case (op)
      ARITH, ARITH_IMM: result = arith_res;
      LUI:              result = src2;
      AUIPC:            result = src1 + src2;
      BRANCH:           result = {{(XLEN-1){1'b0}}, br};
      default:          result = '0;
    endcase
  end
endmodule

// File: rtl/alu_cdb.sv
// alu_cdb: parallel ALU lanes feeding a tag-indexed common data bus register file
module alu_cdb import tomasula_types::alu_word_t; #(
  parameter int NUM_ALU = 4,
  parameter int NUM_ROB = tomasula_types::NUM_ROB,
  parameter int XLEN = tomasula_types::XLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [NUM_ALU-1:0] exec,
  input  alu_word_t         alu_word [NUM_ALU],
  output logic [XLEN-1:0]   alu_result [NUM_ALU],
  output logic [NUM_ROB-1:0] set_rob_valid,
  output logic [XLEN-1:0]   cdb_data [NUM_ROB],
  output logic [NUM_ROB-1:0] cdb_valid
);
  for (genvar g = 0; g < NUM_ALU; g++) begin : g_lane
    alu u_alu (
      .op(alu_word[g].op),
      .funct3(alu_word[g].funct3),
      .funct7(alu_word[g].funct7),
      .src1(alu_word[g].src1),
      .src2(alu_word[g].src2),
      .result(alu_result[g])
    );
  end
  // one-hot tag of every executing lane, merged
  always_comb begin
    set_rob_valid = '0;
    for (int i = 0; i < NUM_ALU; i++)
      if (exec[i]) set_rob_valid[alu_word[i].tag] = 1'b1;
  end
  // ascending lane order makes the highest lane the last writer on tag collisions; flush drops valids but keeps data
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NUM_ROB; j++) cdb_data[j] <= '0;
      cdb_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_ALU; i++)
        if (exec[i]) cdb_data[alu_word[i].tag] <= alu_result[i];
      cdb_valid <= flush ? '0 : cdb_valid | set_rob_valid;
    end
  end
endmodule

// File: tb/tb_alu_cdb.sv
// tb_alu_cdb: randomized and directed checks of alu_cdb against a behavioural model
module tb_alu_cdb;
  import tomasula_types::*;
  logic clk = 1'b0;
  logic rst, flush;
  logic [3:0] exec;
  alu_word_t alu_word [4];
  logic [31:0] alu_result [4];
  logic [7:0] set_rob_valid;
  logic [31:0] cdb_data [8];
  logic [7:0] cdb_valid;
  logic [31:0] m_data [8];
  logic [7:0] m_valid;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_cdb dut (
    .clk(clk), .rst(rst), .flush(flush), .exec(exec), .alu_word(alu_word),
    .alu_result(alu_result), .set_rob_valid(set_rob_valid),
    .cdb_data(cdb_data), .cdb_valid(cdb_valid)
  );

  function automatic logic [31:0] ref_alu(input alu_word_t w);
    logic [31:0] a, b, sa, sb;
    int s;
    a = w.src1;
    b = w.src2;
    s = int'(b[4:0]);
    sa = a ^ 32'h8000_0000;
    sb = b ^ 32'h8000_0000;
    if (w.op == ARITH || w.op == ARITH_IMM) begin
      case (w.funct3)
        3'd0: return (w.op == ARITH && w.funct7) ? a - b : a + b;
        3'd1: return a << s;
        3'd2: return (sa < sb) ? 32'd1 : 32'd0;
        3'd3: return (a < b) ? 32'd1 : 32'd0;
        3'd4: return a ^ b;
        3'd5: return (w.funct7 && a[31]) ? (a >> s) | ~(32'hFFFF_FFFF >> s) : a >> s;
        3'd6: return a | b;
        default: return a & b;
      endcase
    end
    if (w.op == LUI) return b;
    if (w.op == AUIPC) return a + b;
    if (w.op == BRANCH) begin
      case (w.funct3)
        3'd0: return (a == b) ? 32'd1 : 32'd0;
        3'd1: return (a != b) ? 32'd1 : 32'd0;
        3'd4: return (sa < sb) ? 32'd1 : 32'd0;
        3'd5: return (sa >= sb) ? 32'd1 : 32'd0;
        3'd6: return (a < b) ? 32'd1 : 32'd0;
        3'd7: return (a >= b) ? 32'd1 : 32'd0;
        default: return 32'd0;
      endcase
    end
    return 32'd0;
  endfunction

  task automatic set_lane(input int l, input op_t op, input logic [2:0] f3, input logic f7,
                          input logic [31:0] a, input logic [31:0] b, input logic [2:0] tag);
    alu_word[l].op = op;
    alu_word[l].funct3 = f3;
    alu_word[l].funct7 = f7;
    alu_word[l].src1 = a;
    alu_word[l].src2 = b;
    alu_word[l].tag = tag;
  endtask

  task automatic rand_lane(input int l);
    set_lane(l, op_t'(3'($urandom_range(0, 7))), 3'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0) ? 32'h8000_0000 >> $urandom_range(0, 3) : $urandom,
             ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom, 3'($urandom));
  endtask

  task automatic apply(input logic r, input logic f, input logic [3:0] e);
    logic [7:0] exp_srv;
    rst = r;
    flush = f;
    exec = e;
    #2;
    exp_srv = '0;
    for (int l = 0; l < 4; l++) begin
      vectors++;
      if (alu_result[l] !== ref_alu(alu_word[l])) begin
        miscompares++;
        $display("FAIL alu_result[%0d] op=%0d f3=%0d f7=%0b a=%h b=%h got %h want %h", l,
                 alu_word[l].op, alu_word[l].funct3, alu_word[l].funct7, alu_word[l].src1,
                 alu_word[l].src2, alu_result[l], ref_alu(alu_word[l]));
      end
      if (e[l]) exp_srv |= 8'(1) << alu_word[l].tag;
    end
    vectors++;
    if (set_rob_valid !== exp_srv) begin
      miscompares++;
      $display("FAIL set_rob_valid got %h want %h", set_rob_valid, exp_srv);
    end
    @(posedge clk);
    if (r) begin
      for (int t = 0; t < 8; t++) m_data[t] = '0;
      m_valid = '0;
    end else begin
      for (int l = 0; l < 4; l++)
        if (e[l]) begin
          m_data[alu_word[l].tag] = ref_alu(alu_word[l]);
          m_valid[alu_word[l].tag] = 1'b1;
        end
      if (f) m_valid = '0;
    end
    #1;
    vectors++;
    if (cdb_valid !== m_valid) begin
      miscompares++;
      $display("FAIL cdb_valid got %h want %h", cdb_valid, m_valid);
    end
    for (int t = 0; t < 8; t++) begin
      vectors++;
      if (cdb_data[t] !== m_data[t]) begin
        miscompares++;
        $display("FAIL cdb_data[%0d] got %h want %h", t, cdb_data[t], m_data[t]);
      end
    end
  endtask

  task automatic test_reset();
    for (int l = 0; l < 4; l++) rand_lane(l);
    apply(1'b1, 1'b0, 4'b1111);
    apply(1'b1, 1'b1, 4'b0000);
    vectors++;
    if (cdb_valid !== 8'h00 || cdb_data[3] !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_state valid=%h data3=%h want 00/0", cdb_valid, cdb_data[3]);
    end
  endtask

  task automatic test_add();
    set_lane(0, ARITH, 3'b000, 1'b0, 32'd5, 32'd3, 3'd1);
    apply(1'b0, 1'b0, 4'b0001);
    vectors++;
    if (cdb_data[1] !== 32'd8 || cdb_valid !== 8'h02) begin
      miscompares++;
      $display("FAIL add data1=%h valid=%h want 8/02", cdb_data[1], cdb_valid);
    end
  endtask

  task automatic test_sub_sra();
    set_lane(1, ARITH, 3'b000, 1'b1, 32'd3, 32'd5, 3'd2);
    set_lane(2, ARITH, 3'b101, 1'b1, 32'h8000_0000, 32'd4, 3'd3);
    apply(1'b0, 1'b0, 4'b0110);
    vectors++;
    if (cdb_data[2] !== 32'hFFFF_FFFE || cdb_data[3] !== 32'hF800_0000) begin
      miscompares++;
      $display("FAIL sub_sra data2=%h data3=%h want fffffffe/f8000000", cdb_data[2], cdb_data[3]);
    end
  endtask

  task automatic test_imm_add();
    set_lane(0, ARITH_IMM, 3'b000, 1'b1, 32'd0, 32'd11, 3'd4);
    apply(1'b0, 1'b0, 4'b0001);
    vectors++;
    if (cdb_data[4] !== 32'd11) begin
      miscompares++;
      $display("FAIL imm_add data4=%h want 0000000b", cdb_data[4]);
    end
  endtask

  task automatic test_collision();
    set_lane(0, LUI, 3'b000, 1'b0, 32'd0, 32'd7, 3'd5);
    set_lane(3, LUI, 3'b000, 1'b0, 32'd0, 32'd9, 3'd5);
    rst = 1'b0;
    flush = 1'b0;
    exec = 4'b1001;
    #2;
    vectors++;
    if (set_rob_valid !== 8'h20) begin
      miscompares++;
      $display("FAIL collision_srv got %h want 20", set_rob_valid);
    end
    apply(1'b0, 1'b0, 4'b1001);
    vectors++;
    if (cdb_data[5] !== 32'd9) begin
      miscompares++;
      $display("FAIL collision data5=%h want 9", cdb_data[5]);
    end
  endtask

  task automatic test_branch();
    set_lane(0, BRANCH, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1, 3'd0);
    exec = 4'b0000;
    #1;
    vectors++;
    if (alu_result[0] !== 32'd1) begin
      miscompares++;
      $display("FAIL branch_blt got %h want 1", alu_result[0]);
    end
    alu_word[0].funct3 = 3'b110;
    #1;
    vectors++;
    if (alu_result[0] !== 32'd0) begin
      miscompares++;
      $display("FAIL branch_bltu got %h want 0", alu_result[0]);
    end
    apply(1'b0, 1'b0, 4'b0000);
  endtask

  task automatic test_flush_rst();
    logic [31:0] saved [8];
    for (int t = 0; t < 8; t++) begin
      rand_lane(0);
      alu_word[0].tag = 3'(t);
      apply(1'b0, 1'b0, 4'b0001);
    end
    vectors++;
    if (cdb_valid !== 8'hFF) begin
      miscompares++;
      $display("FAIL fill_valid got %h want ff", cdb_valid);
    end
    for (int t = 0; t < 8; t++) saved[t] = m_data[t];
    apply(1'b0, 1'b1, 4'b0000);
    for (int t = 0; t < 8; t++) begin
      vectors++;
      if (cdb_data[t] !== saved[t]) begin
        miscompares++;
        $display("FAIL flush_keep[%0d] got %h want %h", t, cdb_data[t], saved[t]);
      end
    end
    set_lane(2, LUI, 3'b000, 1'b0, 32'd0, 32'h1234_5678, 3'd6);
    apply(1'b0, 1'b1, 4'b0100);
    vectors++;
    if (cdb_valid !== 8'h00 || cdb_data[6] !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL flush_exec valid=%h data6=%h want 00/12345678", cdb_valid, cdb_data[6]);
    end
    apply(1'b1, 1'b1, 4'b1111);
    vectors++;
    if (cdb_data[6] !== 32'd0 || cdb_valid !== 8'h00) begin
      miscompares++;
      $display("FAIL rst_clear data6=%h valid=%h want 0/00", cdb_data[6], cdb_valid);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int l = 0; l < 4; l++) rand_lane(l);
      apply($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0, 4'($urandom));
    end
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    exec = '0;
    for (int l = 0; l < 4; l++) set_lane(l, ARITH, 3'b000, 1'b0, 32'd0, 32'd0, 3'd0);
    for (int t = 0; t < 8; t++) m_data[t] = '0;
    m_valid = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_add();
    test_sub_sra();
    test_imm_add();
    test_collision();
    test_branch();
    test_flush_rst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
